// File: rtl/operand_collector4.sv
// Operand collector: packs four serial WIDTH-bit operands into one parallel
// bundle (x1..x4) for the four-operand adder stage, with valid/ready on both
// sides and a free-running count of handed-off bundles.
module operand_collector4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  output logic [1:0]       slot,
  output logic [CNT_W-1:0] bundle_cnt
);

  typedef enum logic {StCollect, StPresent} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] x3_q, x3_d;
  logic [WIDTH-1:0] x4_q, x4_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    x4_d        = x4_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    cnt_d       = cnt_q;

    if (flush) begin
      // Drops any same-cycle operand and any same-cycle handoff.
      state_d     = StCollect;
      slot_d      = 2'd0;
      x1_d        = '0;
      x2_d        = '0;
      x3_d        = '0;
      x4_d        = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        StCollect: begin
          if (in_valid && in_ready_q) begin
            case (slot_q)
              2'd0:    x1_d = in_data;
              2'd1:    x2_d = in_data;
              2'd2:    x3_d = in_data;
              default: x4_d = in_data;
            endcase
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              state_d     = StPresent;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
            end
          end
        end
        default: begin
          // x1..x4 are deliberately left as-is after handoff.
          if (out_ready) begin
            cnt_d       = cnt_q + 1'b1;
            state_d     = StCollect;
            slot_d      = 2'd0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StCollect;
      slot_q      <= 2'd0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      x4_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      x4_q        <= x4_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign x1         = x1_q;
  assign x2         = x2_q;
  assign x3         = x3_q;
  assign x4         = x4_q;
  assign slot       = slot_q;
  assign bundle_cnt = cnt_q;

endmodule

// File: tb/tb_operand_collector4.sv
// Directed bench for operand_collector4: vector table for the common flows,
// hand sequences for async reset and the 256-bundle counter wrap.
module tb_operand_collector4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] x1, x2, x3, x4;
  logic [1:0] slot;
  logic [7:0] bundle_cnt;

  int total = 0;
  int bad   = 0;

  operand_collector4 #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .slot      (slot),
    .bundle_cnt(bundle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [3:0]  d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [1:0]  sl;
    logic [15:0] x;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [3:0] d, input logic ordy, input logic fl,
                     input logic ov, input logic ir, input logic [1:0] sl,
                     input logic [15:0] x, input logic [7:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ir = ir; v.sl = sl; v.x = x; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic ir,
                           input logic [1:0] sl, input logic [15:0] x, input logic [7:0] cnt);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    check({tag, ".slot"}, {30'd0, slot}, {30'd0, sl});
    check({tag, ".x"}, {16'd0, x1, x2, x3, x4}, {16'd0, x});
    check({tag, ".bundle_cnt"}, {24'd0, bundle_cnt}, {24'd0, cnt});
  endtask

  // Advance one edge and settle outputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    #12;
    check_all("reset", 1'b0, 1'b1, 2'd0, 16'h0000, 8'd0);
    #1;
    rst = 1'b0;

    // 1: back-to-back 3,5,2,1 with out_ready high
    add(1, 4'h3, 1, 0, 0, 1, 2'd1, 16'h3000, 8'd0);
    add(1, 4'h5, 1, 0, 0, 1, 2'd2, 16'h3500, 8'd0);
    add(1, 4'h2, 1, 0, 0, 1, 2'd3, 16'h3520, 8'd0);
    add(1, 4'h1, 1, 0, 1, 0, 2'd0, 16'h3521, 8'd0);
    add(0, 4'h0, 1, 0, 0, 1, 2'd0, 16'h3521, 8'd1);
    // 2: A,B,C,D then 6 stalled cycles (offered operands ignored), then handoff
    add(1, 4'hA, 0, 0, 0, 1, 2'd1, 16'hA521, 8'd1);
    add(1, 4'hB, 0, 0, 0, 1, 2'd2, 16'hAB21, 8'd1);
    add(1, 4'hC, 0, 0, 0, 1, 2'd3, 16'hABC1, 8'd1);
    add(1, 4'hD, 0, 0, 1, 0, 2'd0, 16'hABCD, 8'd1);
    for (int i = 0; i < 6; i++) add(1, 4'hF, 0, 0, 1, 0, 2'd0, 16'hABCD, 8'd1);
    add(1, 4'hE, 1, 0, 0, 1, 2'd0, 16'hABCD, 8'd2);
    // 3: gaps between operands
    add(1, 4'h1, 0, 0, 0, 1, 2'd1, 16'h1BCD, 8'd2);
    add(0, 4'h5, 0, 0, 0, 1, 2'd1, 16'h1BCD, 8'd2);
    add(1, 4'h2, 0, 0, 0, 1, 2'd2, 16'h12CD, 8'd2);
    add(0, 4'h6, 0, 0, 0, 1, 2'd2, 16'h12CD, 8'd2);
    add(1, 4'h3, 0, 0, 0, 1, 2'd3, 16'h123D, 8'd2);
    add(1, 4'h4, 0, 0, 1, 0, 2'd0, 16'h1234, 8'd2);
    add(0, 4'h0, 1, 0, 0, 1, 2'd0, 16'h1234, 8'd3);
    // 4: flush mid-bundle drops the same-cycle 9
    add(1, 4'h7, 0, 0, 0, 1, 2'd1, 16'h7234, 8'd3);
    add(1, 4'h7, 0, 0, 0, 1, 2'd2, 16'h7734, 8'd3);
    add(1, 4'h9, 0, 1, 0, 1, 2'd0, 16'h0000, 8'd3);
    add(1, 4'h1, 0, 0, 0, 1, 2'd1, 16'h1000, 8'd3);
    add(1, 4'h2, 0, 0, 0, 1, 2'd2, 16'h1200, 8'd3);
    add(1, 4'h3, 0, 0, 0, 1, 2'd3, 16'h1230, 8'd3);
    add(1, 4'h4, 0, 0, 1, 0, 2'd0, 16'h1234, 8'd3);
    add(0, 4'h0, 1, 0, 0, 1, 2'd0, 16'h1234, 8'd4);
    // 5: flush together with out_ready in PRESENT discards the bundle
    add(1, 4'h5, 0, 0, 0, 1, 2'd1, 16'h5234, 8'd4);
    add(1, 4'h6, 0, 0, 0, 1, 2'd2, 16'h5634, 8'd4);
    add(1, 4'h7, 0, 0, 0, 1, 2'd3, 16'h5674, 8'd4);
    add(1, 4'h8, 0, 0, 1, 0, 2'd0, 16'h5678, 8'd4);
    add(0, 4'h0, 1, 1, 0, 1, 2'd0, 16'h0000, 8'd4);

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].sl, vecs[i].x,
                vecs[i].cnt);
    end

    // Async reset mid-COLLECT: outputs clear with no clock edge.
    in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b0; flush = 1'b0;
    tick();
    in_data = 4'hA;
    tick();
    check_all("pre_rst", 1'b0, 1'b1, 2'd2, 16'h9A00, 8'd4);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b1, 2'd0, 16'h0000, 8'd0);
    #1;
    rst = 1'b0;

    // 6: 256 back-to-back bundles, 5-cycle period, counter wraps to 0.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 256 * 5; c++) begin
      in_data = 4'(c);
      tick();
      if (c % 5 == 3) begin
        check($sformatf("b2b_ov%0d", c / 5), {31'd0, out_valid}, 32'd1);
      end else if (c % 5 == 4) begin
        check($sformatf("b2b_cnt%0d", c / 5), {24'd0, bundle_cnt}, 32'((c / 5 + 1) % 256));
        check($sformatf("b2b_ir%0d", c / 5), {31'd0, in_ready}, 32'd1);
      end
    end
    in_valid = 1'b0;
    tick();
    check("wrap_final", {24'd0, bundle_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
